uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1-style transmitter in the AHB UART peripheral. It pops bytes from the TX FIFO and serialises them on `tx`. Data width, FIFO read latency and the baud divider are configurable. Parity mode and stop-bit count are selected at run time from UART control-register fields. It sits between the AHB UART register/FIFO logic and the pad.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..8.
DIV_W, 16, width of the baud divider input.
RD_LAT, 2, cycles from `re_o` to valid `data_i` (FIFO read register plus async-FIFO output stage); legal range 1..4.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
data_i  input  DATA_W  FIFO read data, valid RD_LAT cycles after `re_o`.
empty_i  input  1  FIFO empty flag.
re_o  output  1  FIFO read enable, one-cycle pulse per frame.
baud_div_i  input  DIV_W  clocks per bit minus 1.
parity_i  input  2  parity mode: 00 none, 01 odd, 10 even, 11 treated as none.
stop2_i  input  1  0 = one stop bit, 1 = two stop bits.
tx  output  1  serial line, registered.
busy_o  output  1  high from the `re_o` cycle until the end of the last stop bit.
done_o  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (async, any state): state=IDLE; tx=1, re_o=0, busy_o=0, done_o=0; counters=0. A frame in progress is abandoned and the line returns to idle-high immediately. The FIFO word already popped is lost.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - If !empty_i, then re_o=1 (combinational) for that cycle → FETCH.
  - Otherwise stay in IDLE with tx=1.
- FETCH:
  - Waits RD_LAT cycles, counting from the `re_o` cycle.
  - In the cycle where the count equals RD_LAT, capture data_i into the shift register.
  - In that same cycle, latch baud_div_i, parity_i and stop2_i into frame config. Config changes mid-frame have no effect.
  - → START.
- Bit timing: every bit lasts exactly (div+1) clk cycles, using the latched div. div=0 means one clock per bit. A down-counter reloads on each bit boundary.
- START: tx=0 for one bit time → DATA.
- DATA:
  - LSB first, DATA_W bits; shift right on each bit boundary.
  - Parity accumulator: starts at 1 for odd or 0 for even, and XORs each transmitted data bit.
  - After bit DATA_W-1 → PARITY if parity is enabled, else → STOP.
- PARITY: tx = accumulator for one bit time → STOP.
- STOP:
  - tx=1 for 1 bit time, or 2 if stop2 is latched.
  - done_o pulses in the last cycle → IDLE.
- Frame length in clk cycles: (div+1) × (1 + DATA_W + P + S), where P is 0 or 1 and S is 1 or 2.
- Back-to-back frames:
  - The earliest next `re_o` is the first IDLE cycle after done_o.
  - The inter-frame gap on the line is RD_LAT+1 cycles of idle-high beyond the stop bits.
- `re_o` is never asserted outside IDLE. `empty_i` is sampled only in IDLE.
- `busy_o` is combinational: high whenever state≠IDLE, and also high during the IDLE cycle that asserts `re_o`.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input `break_i` (1 bit).
  - While in IDLE with break_i=1: tx=0, no FIFO reads, busy_o=1.
  - break_i asserted mid-frame takes effect only after the current frame's done_o.
  - Deasserting break_i returns tx to 1 in the next cycle.
- Undefined: port absent, no break logic.

Decomposition:
- Package `uart_pkg` holds:
  - parity-mode encodings (PAR_NONE/PAR_ODD/PAR_EVEN);
  - the state encoding localparams;
  - legal DATA_W/RD_LAT bounds.
- Sub-module `uart_baud_cnt`:
  - inputs: load, div;
  - output: bit_end pulse.
  - The same sub-module is reused by the RX side.

Test Plan:
- DATA_W=8, RD_LAT=2, div=3, parity none, stop1, FIFO holds 0x55:
  - re_o at cycle t;
  - tx=0 for cycles t+3..t+6, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop 1 for 4 cycles;
  - done_o at t+42.
- div=0, odd parity, data 0x07 → parity bit 0. Even parity, 0x07 → parity bit 1. Total frame = 11 cycles (div=0, 1+8+1+1 bits).
- stop2_i=1, DATA_W=5, data 0x1F, div=1 → frame = 2×(1+5+0+2) = 16 cycles. stop2_i toggled mid-frame has no effect.
- Two words queued (0xA5, 0x3C) → exactly two re_o pulses; second start bit begins RD_LAT+1 cycles after the first done_o; empty_i held high afterwards → no further re_o.
- rst_n pulsed low during DATA bit 4 → tx=1 asynchronously, busy_o=0; after release with empty_i=1 the line stays idle-high.
- UART_TX_BREAK_EN: break_i raised mid-frame → frame completes, then tx=0 with no re_o despite !empty_i; break_i released → tx=1 next cycle, re_o follows.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter (and receiver) blocks.
//   - parity-mode encodings as carried in the UART control register
//   - frame state encoding
//   - legal DATA_W / RD_LAT bounds
//   - par_enabled(): true when the parity field selects a parity bit
package uart_pkg;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 8;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10,
        PAR_RSVD = 2'b11   // behaves as PAR_NONE
    } par_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: TX FIFO read port between the AHB UART FIFO and the
// transmitter.
//   data_i  : FIFO read data, valid RD_LAT cycles after re_o
//   empty_i : FIFO empty flag
//   re_o    : FIFO read enable (one-cycle pulse per frame)
// Modports: master = transmitter side, slave = FIFO side.
interface uart_tx_frame_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data_i;
    logic              empty_i;
    logic              re_o;

    modport master (input data_i, input empty_i, output re_o);
    modport slave  (output data_i, output empty_i, input re_o);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period down-counter shared by the UART TX and RX paths.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the bit period from div
//   div        : clocks per bit minus 1
//   bit_end    : high in the last clock of each bit period
// The counter reloads from div on every bit boundary, so each bit lasts
// exactly div+1 clocks (div=0 gives bit_end every clock).
module uart_baud_cnt #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        bit_end = (cnt_q == '0);
        cnt_d   = cnt_q - DIV_W'(1);
        if (load || bit_end) begin
            cnt_d = div;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter. Pops one word per frame from
// the TX FIFO and serialises it LSB first as start / data / [parity] / stop(s).
//   clk, rst_n  : clock, asynchronous active-low reset
//   fifo        : FIFO read port (data_i, empty_i, re_o), master side
//   baud_div_i  : clocks per bit minus 1 (latched per frame)
//   parity_i    : 00 none, 01 odd, 10 even, 11 none (latched per frame)
//   stop2_i     : 0 one stop bit, 1 two stop bits (latched per frame)
//   break_i     : only with UART_TX_BREAK_EN; holds the line low between frames
//   tx          : serial line, registered, idle high
//   busy_o      : from the re_o cycle to the end of the last stop bit
//   done_o      : pulse in the final clock of the last stop bit
// Optional feature macro: UART_TX_BREAK_EN (adds break_i).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_frame_if.master        fifo,
    input  logic [DIV_W-1:0]       baud_div_i,
    input  logic [1:0]             parity_i,
    input  logic                   stop2_i,
`ifdef UART_TX_BREAK_EN
    input  logic                   break_i,
`endif
    output logic                   tx,
    output logic                   busy_o,
    output logic                   done_o
);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
        RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_param_err
        $error("uart_tx_frame: DATA_W or RD_LAT outside legal range");
    end

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        mode_q, mode_d;
    logic              stop2_q, stop2_d;
    logic              par_q, par_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;     // data bit index, then stop bit index
    logic [2:0]        fetch_cnt_q, fetch_cnt_d; // 1..RD_LAT while waiting on FIFO data
    logic              tx_q, tx_d;

    logic              brk;
    logic              re;
    logic              load;
    logic              bit_end;
    logic [DIV_W-1:0]  baud_div;

`ifdef UART_TX_BREAK_EN
    assign brk = break_i;
`else
    assign brk = 1'b0;
`endif

    // break and empty_i only matter in IDLE, so a mid-frame break waits for done_o
    assign re        = (state_q == ST_IDLE) && !fifo.empty_i && !brk;
    assign fifo.re_o = re;

    // The first bit period must use the divider being latched in the same cycle.
    assign baud_div = load ? baud_div_i : div_q;

    uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .div     (baud_div),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            div_q       <= '0;
            mode_q      <= '0;
            stop2_q     <= 1'b0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            fetch_cnt_q <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            stop2_q     <= stop2_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            tx_q        <= tx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        div_d       = div_q;
        mode_d      = mode_q;
        stop2_d     = stop2_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        load        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (re) begin
                    state_d     = ST_FETCH;
                    fetch_cnt_d = 3'd1;
                end
            end
            ST_FETCH: begin
                if (fetch_cnt_q == 3'(RD_LAT)) begin
                    shift_d = fifo.data_i;
                    div_d   = baud_div_i;
                    mode_d  = parity_i;
                    stop2_d = stop2_i;
                    par_d   = (parity_i == PAR_ODD);
                    load    = 1'b1;
                    state_d = ST_START;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 3'd1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 3'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_enabled(mode_q) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q[0] == stop2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tx is registered, so its next value follows the next state: the line
    // changes in the same clock the state does.
    always_comb begin
        busy_o = (state_q != ST_IDLE) || re || brk;
        done_o = (state_q == ST_STOP) && bit_end && (bit_cnt_q[0] == stop2_q);
        tx_d   = 1'b1;
        unique case (state_d)
            ST_IDLE:   tx_d = !brk;
            ST_FETCH:  tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8-bit / RD_LAT=2 instance fed from a FIFO model
// and a 5-bit / RD_LAT=1 instance driven by hand.
module tb_uart_tx_frame;

    localparam int unsigned DW   = 8;
    localparam int unsigned DIVW = 16;
    localparam int unsigned LAT  = 2;
    localparam int unsigned DW5  = 5;
    localparam int unsigned LAT5 = 1;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [1:0]  par;
        logic        stop2;
        int unsigned exp_len;
        logic        exp_par;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_W(DW))  bus ();
    uart_tx_frame_if #(.DATA_W(DW5)) bus5 ();

    logic [DIVW-1:0] div8 = '0, div5 = '0;
    logic [1:0]      par8 = '0, par5 = '0;
    logic            stop8 = 1'b0, stop5 = 1'b0;
    logic            tx8, busy8, done8, tx5, busy5, done5;
`ifdef UART_TX_BREAK_EN
    logic            brk8 = 1'b0;
    logic            brk5 = 1'b0;
`endif

    uart_tx_frame #(.DATA_W(DW), .DIV_W(DIVW), .RD_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo       (bus),
        .baud_div_i (div8),
        .parity_i   (par8),
        .stop2_i    (stop8),
`ifdef UART_TX_BREAK_EN
        .break_i    (brk8),
`endif
        .tx         (tx8),
        .busy_o     (busy8),
        .done_o     (done8)
    );

    uart_tx_frame #(.DATA_W(DW5), .DIV_W(DIVW), .RD_LAT(LAT5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo       (bus5),
        .baud_div_i (div5),
        .parity_i   (par5),
        .stop2_i    (stop5),
`ifdef UART_TX_BREAK_EN
        .break_i    (brk5),
`endif
        .tx         (tx5),
        .busy_o     (busy5),
        .done_o     (done5)
    );

    // FIFO model: read data appears LAT cycles after re_o, random otherwise.
    logic [DW-1:0] mem  [16];
    logic [DW-1:0] pipe [LAT];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;

    assign bus.empty_i = (rd_ptr >= wr_ptr);
    assign bus.data_i  = pipe[LAT-1];

    always @(posedge clk) begin
        if (bus.re_o) begin
            pipe[0] <= mem[rd_ptr[3:0]];
            rd_ptr  <= rd_ptr + 1;
        end else begin
            pipe[0] <= DW'($urandom);
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    logic empty5 = 1'b1;
    assign bus5.empty_i = empty5;
    assign bus5.data_i  = DW5'(5'h1F);

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    vec_t        sb [$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic model_tx(input vec_t v, input int unsigned i);
        int unsigned b;
        logic        pe;
        b  = i / (32'(v.div) + 1);
        pe = (v.par == 2'b01) || (v.par == 2'b10);
        if (b == 0) return 1'b0;
        if (b <= DW) return v.data[b-1];
        if (pe && b == DW + 1) return (v.par == 2'b01) ^ (^v.data);
        return 1'b1;
    endfunction

    task automatic push_word(input vec_t v);
        mem[wr_ptr[3:0]] = v.data;
        wr_ptr++;
        sb.push_back(v);
    endtask

    task automatic wait_re(output int unsigned n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.re_o && n < 40);
    endtask

    // Entered at the negedge of the re_o cycle; returns at the done_o negedge.
    task automatic check_frame(input vec_t v, input bit scramble);
        int unsigned len = 0;
        int unsigned bad_i = 0;
        logic        bad = 1'b0;
        logic        bad_tx = 1'b0;
        logic        par_seen = 1'b0;
        logic        side_ok = 1'b1;
        chk("busy_at_re", 32'(busy8), 1);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            if (tx8 !== 1'b1 || busy8 !== 1'b1 || bus.re_o !== 1'b0 || done8 !== 1'b0) side_ok = 1'b0;
        end
        for (int unsigned i = 0; i < 300; i++) begin
            @(negedge clk);
            if (scramble && i == 1) begin
                div8  = 16'($urandom_range(0, 65535));
                par8  = 2'($urandom);
                stop8 = ~stop8;
            end
            if (!bad && tx8 !== model_tx(v, i)) begin
                bad    = 1'b1;
                bad_i  = i;
                bad_tx = tx8;
            end
            if (i == (32'(v.div) + 1) * (1 + DW)) par_seen = tx8;
            if (busy8 !== 1'b1 || bus.re_o !== 1'b0) side_ok = 1'b0;
            len++;
            if (done8) break;
        end
        chk("frame_len", len, v.exp_len);
        chk("side_signals", 32'(side_ok), 1);
        if (v.par == 2'b01 || v.par == 2'b10) chk("parity_bit", 32'(par_seen), 32'(v.exp_par));
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL wave: frame cycle %0d tx=%b expected %b", bad_i, bad_tx, ~bad_tx);
        end
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        chk("idle_tx", 32'(tx8), 1);
        chk("idle_busy", 32'(busy8), 0);
        chk("done_single", 32'(done8), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [7];
        vec_t        e;
        vec_t        w;
        int unsigned n;
        int unsigned cnt;
        logic        ok;

        vecs[0] = '{8'h55, 16'd3, 2'b00, 1'b0, 40, 1'b0};
        vecs[1] = '{8'h07, 16'd0, 2'b01, 1'b0, 11, 1'b0};
        vecs[2] = '{8'h07, 16'd0, 2'b10, 1'b0, 11, 1'b1};
        vecs[3] = '{8'hA3, 16'd2, 2'b11, 1'b1, 33, 1'b0};
        vecs[4] = '{8'h00, 16'd1, 2'b01, 1'b1, 24, 1'b1};
        vecs[5] = '{8'hFF, 16'd0, 2'b10, 1'b0, 11, 1'b0};
        vecs[6] = '{8'h80, 16'd5, 2'b01, 1'b0, 66, 1'b0};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx8), 1);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_re", 32'(bus.re_o), 0);
        chk("rst_tx5", 32'(tx5), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // table-driven frames, config scrambled after capture
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            div8  = vecs[k].div;
            par8  = vecs[k].par;
            stop8 = vecs[k].stop2;
            push_word(vecs[k]);
            wait_re(n);
            chk("re_seen", 32'(bus.re_o), 1);
            e = sb.pop_front();
            check_frame(e, 1'b1);
            check_idle_after();
        end

        // back-to-back words
        @(posedge clk);
        #1;
        div8 = 16'd1; par8 = 2'b10; stop8 = 1'b0;
        w = '{8'hA5, 16'd1, 2'b10, 1'b0, 22, 1'b0};
        push_word(w);
        w = '{8'h3C, 16'd1, 2'b10, 1'b0, 22, 1'b0};
        push_word(w);
        wait_re(n);
        chk("b2b_re1", 32'(bus.re_o), 1);
        e = sb.pop_front();
        check_frame(e, 1'b0);
        wait_re(n);
        chk("b2b_gap", n, 1);
        e = sb.pop_front();
        check_frame(e, 1'b0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.re_o) cnt++;
        end
        chk("b2b_extra_re", cnt, 0);
        chk("b2b_pops", rd_ptr, wr_ptr);

        // 5-bit instance: two stop bits, stop2 cleared mid-frame
        div5 = 16'd1; par5 = 2'b00; stop5 = 1'b1;
        @(posedge clk);
        #1 empty5 = 1'b0;
        @(negedge clk);
        chk("re5", 32'(bus5.re_o), 1);
        @(posedge clk);
        #1 empty5 = 1'b1;
        cnt = 0; n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == LAT5 + 2) stop5 = 1'b0;
            if (tx5 == 1'b0) cnt++;
            n++;
            if (done5) break;
        end
        chk("len5", n, LAT5 + 16);
        chk("low5", cnt, 2);

        // asynchronous reset during data bit 4 (0x0F: bit 4 is 0)
        @(posedge clk);
        #1;
        div8 = 16'd1; par8 = 2'b00; stop8 = 1'b0;
        mem[wr_ptr[3:0]] = 8'h0F;
        wr_ptr++;
        wait_re(n);
        chk("rst_test_re", 32'(bus.re_o), 1);
        repeat (LAT + 1 + 10) @(negedge clk);
        chk("pre_rst_tx", 32'(tx8), 0);
        chk("pre_rst_busy", 32'(busy8), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx8), 1);
        chk("async_rst_busy", 32'(busy8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx8 !== 1'b1 || busy8 !== 1'b0 || bus.re_o !== 1'b0) ok = 1'b0;
        end
        chk("post_rst_idle", 32'(ok), 1);

`ifdef UART_TX_BREAK_EN
        @(posedge clk);
        #1;
        div8 = 16'd0; par8 = 2'b00; stop8 = 1'b0;
        w = '{8'h5A, 16'd0, 2'b00, 1'b0, 10, 1'b0};
        push_word(w);
        wait_re(n);
        chk("brk_re1", 32'(bus.re_o), 1);
        e = sb.pop_front();
        fork
            begin
                repeat (LAT + 3) @(negedge clk);
                brk8 = 1'b1;
                push_word('{8'hC3, 16'd0, 2'b00, 1'b0, 10, 1'b0});
            end
        join_none
        check_frame(e, 1'b0);
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (tx8 !== 1'b0 || bus.re_o !== 1'b0 || busy8 !== 1'b1) ok = 1'b0;
        end
        chk("break_hold", 32'(ok), 1);
        @(posedge clk);
        #1 brk8 = 1'b0;
        @(negedge clk);
        chk("brk_release_re", 32'(bus.re_o), 1);
        e = sb.pop_front();
        check_frame(e, 1'b0);
        check_idle_after();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
